// File: rtl/alu_exec_iter.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops and one-bit-per-cycle shifts.
// Accepts one op per valid/ready handshake and holds a registered result until it is taken.
module alu_exec_iter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_SLL = 3'b101,
        OP_SRL = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    state_e              state_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     result_q;
    logic                zero_q;
    logic [XLEN-1:0]     work_q;
    logic [XLEN-1:0]     work_d;
    logic [SHAMT_W-1:0]  cnt_q;
    logic [SHAMT_W-1:0]  cnt_d;
    logic                srl_q;

    op_e                 op;
    logic [SHAMT_W-1:0]  shamt;
    logic                is_shift;
    logic [XLEN-1:0]     alu_res;

    assign op       = op_e'(alu_op);
    assign shamt    = op_b[SHAMT_W-1:0];
    assign is_shift = (op == OP_SLL) || (op == OP_SRL);

    // A zero-count shift falls through to this path and returns op_a unchanged.
    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a;
            OP_SRL:  alu_res = op_a;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        work_d = srl_q ? {1'b0, work_q[XLEN-1:1]} : {work_q[XLEN-2:0], 1'b0};
        cnt_d  = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            work_q      <= '0;
            cnt_q       <= '0;
            srl_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (is_shift && (shamt != '0)) begin
                            work_q  <= op_a;
                            cnt_q   <= shamt;
                            srl_q   <= (op == OP_SRL);
                            state_q <= S_SHIFT;
                        end else begin
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_d;
                    if (cnt_d == '0) begin
                        result_q    <= work_d;
                        zero_q      <= (work_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_iter.sv
// Directed bench for alu_exec_iter: hand-computed results, latencies and handshake behaviour.
module tb_alu_exec_iter;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] OR_ = 3'b010;
    localparam logic [2:0] AND_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100;
    localparam logic [2:0] SLL = 3'b101;
    localparam logic [2:0] SRL = 3'b110;
    localparam logic [2:0] SLT = 3'b111;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_iter #(.XLEN(XLEN), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op with out_ready high; latency counts samples #1 after each edge, accept edge = 1.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int k;
        int busy;
        @(negedge clk);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        alu_op    = op;
        op_a      = a;
        op_b      = b;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = 3'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        k    = 1;
        busy = in_ready ? 0 : 1;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (!in_ready) busy++;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_busy"}, busy, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
        @(posedge clk);
        #1;
        check({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_post_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = '0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);

        run_op("add",      ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1);
        run_op("sub_wrap", SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1);
        run_op("sub_zero", SUB,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1);
        run_op("or",       OR_,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
        run_op("and",      AND_, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1);
        run_op("xor",      XOR_, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1);
        run_op("slt_neg",  SLT,  32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1);
        run_op("slt_rev",  SLT,  32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 1);
        run_op("sll4",     SLL,  32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 5);
        run_op("srl4",     SRL,  32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 5);
        run_op("srl31",    SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32);
        run_op("sll0",     SLL,  32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1);
        run_op("sll_out",  SLL,  32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 2);

        // Backpressure: result must hold and a pending request must not be taken.
        @(negedge clk);
        in_valid  = 1'b1;
        alu_op    = ADD;
        op_a      = 32'h0000_0100;
        op_b      = 32'h0000_0023;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_result", result, 32'h0000_0123);
        alu_op = SUB;
        op_a   = 32'h0000_1000;
        op_b   = 32'h0000_0001;
        bad    = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (result !== 32'h0000_0123 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("bp_stable", bad, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_valid", {31'd0, out_valid}, 32'd1);
        check("bp_second_result", result, 32'h0000_0FFF);
        @(posedge clk);
        #1;
        check("bp_second_done", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of a 20-step shift.
        @(negedge clk);
        in_valid = 1'b1;
        alu_op   = SRL;
        op_a     = 32'hFFFF_FFFF;
        op_b     = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        check("mid_rst_no_stale", bad, 0);
        run_op("add_after_rst", ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_iter.md
Name: alu_exec_iter

Overview:
- Execute-stage ALU datapath driven by the 3-bit alu_op code from the ALU control decoder. It is the consumer end of the alu_op interface.
- Accepts one operation per handshake and returns one registered result.
- Logic/arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, to save area.
- Sits between the operand mux and the writeback/branch logic.

Parameters:
- XLEN, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; shift count is op_b[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- alu_op  input  3  000 ADD, 001 SUB, 010 OR, 011 AND, 100 XOR, 101 SLL, 110 SRL, 111 SLT(signed)
- op_a  input  XLEN  operand A
- op_b  input  XLEN  operand B / shift amount
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  registered result
- zero  output  1  registered (result == 0)

Behaviour:
- Reset (async, active-high, immediate): state=IDLE, out_valid=0, result=0, zero=1, in_ready=1, internal shift counter=0.
- in_ready = (state==IDLE). Purely a function of state; it does not depend on in_valid.
- Accept occurs when in_valid && in_ready at a rising edge. alu_op, op_a and op_b are captured at accept. Later input changes have no effect on the operation.
- States: IDLE, SHIFT, DONE.
- IDLE, accept, non-shift op: compute, load result/zero, go to DONE. out_valid=1 the next cycle (latency 1).
- IDLE, accept, SLL/SRL with count n>0: load working reg=op_a and counter=n, go to SHIFT.
- IDLE, accept, SLL/SRL with count n=0: result=op_a, go to DONE (latency 1).
- SHIFT: each cycle shift the working reg by 1 (SLL: <<1 zero-fill; SRL: >>1 zero-fill) and decrement the counter. When the counter reaches 0, load result/zero and go to DONE.
- Shift latency is n+1 cycles from accept to out_valid. Max is 2^SHAMT_W = 32 cycles for n=31.
- Upper bits of op_b above SHAMT_W are ignored.
- DONE: out_valid=1. result and zero are held stable until out_ready. On out_valid && out_ready, go to IDLE with out_valid=0.
- No accept in the DONE cycle. in_ready returns the cycle after the output handshake.
- Maximum throughput is 1 op per 2 cycles.
- Arithmetic: ADD/SUB are modulo 2^XLEN, with no carry/overflow output. SLT compares op_a and op_b as two's-complement and gives result = {XLEN-1 zeros, lt}.
- zero is computed from the final result value in the same edge that loads result.
- out_valid=0 in IDLE/SHIFT. result/zero retain their last values outside DONE. Consumers must qualify them with out_valid.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation. No result is produced for it, and the reset values apply.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored. The requester must hold its request until accepted.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, result=0, zero=1.
- ADD 0x0000_0005+0x0000_0003 → out_valid 1 cycle after accept, result=0x0000_0008, zero=0.
- SUB 0x0000_0000−0x0000_0001 → result=0xFFFF_FFFF.
- SUB 7−7 → result=0, zero=1.
- SLT signed checks:
  - 0xFFFF_FFFE (−2) vs 0x0000_0001 → result=1.
  - Reversed operands → result=0.
- SLL 0x0000_0001 by op_b=0xFFFF_FFE4 (n=4) → in_ready=0 for 5 cycles, result=0x0000_0010 with out_valid exactly 5 cycles after accept.
- SRL 0x8000_0000 by 31 → result=0x0000_0001 at 32 cycles.
- Shift by 0 → result=op_a at 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new operands → result stable, no second accept. Release → in_ready=1 next cycle, second op then completes correctly.
- Assert rst during SHIFT (n=20, cycle 8) → immediate IDLE, out_valid=0. The next ADD completes normally with no stale result.
